// File: rtl/vga_raster_driver.sv
// vga_raster_driver: raster counters plus latency-aligned, registered VGA DAC output stage
// Ports: CLOCK/RESET (sync, active-high); PixBus {B,G,R} in, valid PIX_LATENCY cycles after counters;
//   CounterX/CounterY raster position; FrameStart pulse at (0,0); VGA_R/G/B, VGA_HS, VGA_VS,
//   VGA_BLANK_N registered DAC pins lagging the counters by PIX_LATENCY+1; VGA_SYNC_N tied low.
module vga_raster_driver #(
  parameter int R_WIDTH      = 8,
  parameter int G_WIDTH      = 8,
  parameter int B_WIDTH      = 8,
  parameter int CNTR_WIDTH_H = 11,
  parameter int CNTR_WIDTH_V = 10,
  parameter int H_ACTIVE     = 1024,
  parameter int H_FP         = 24,
  parameter int H_SYNC       = 136,
  parameter int H_BP         = 160,
  parameter int V_ACTIVE     = 768,
  parameter int V_FP         = 3,
  parameter int V_SYNC       = 6,
  parameter int V_BP         = 29,
  parameter int PIX_LATENCY  = 2
) (
  input  logic                                 CLOCK,
  input  logic                                 RESET,
  input  logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]   PixBus,
  output logic [CNTR_WIDTH_H-1:0]              CounterX,
  output logic [CNTR_WIDTH_V-1:0]              CounterY,
  output logic                                 FrameStart,
  output logic [R_WIDTH-1:0]                   VGA_R,
  output logic [G_WIDTH-1:0]                   VGA_G,
  output logic [B_WIDTH-1:0]                   VGA_B,
  output logic                                 VGA_HS,
  output logic                                 VGA_VS,
  output logic                                 VGA_BLANK_N,
  output logic                                 VGA_SYNC_N
);
  localparam int PW = R_WIDTH + G_WIDTH + B_WIDTH;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNTR_WIDTH_H-1:0] H_LAST = CNTR_WIDTH_H'(HT - 1);
  localparam logic [CNTR_WIDTH_H-1:0] H_ACT  = CNTR_WIDTH_H'(H_ACTIVE);
  localparam logic [CNTR_WIDTH_H-1:0] H_S0   = CNTR_WIDTH_H'(H_ACTIVE + H_FP);
  localparam logic [CNTR_WIDTH_H-1:0] H_S1   = CNTR_WIDTH_H'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNTR_WIDTH_V-1:0] V_LAST = CNTR_WIDTH_V'(VT - 1);
  localparam logic [CNTR_WIDTH_V-1:0] V_ACT  = CNTR_WIDTH_V'(V_ACTIVE);
  localparam logic [CNTR_WIDTH_V-1:0] V_S0   = CNTR_WIDTH_V'(V_ACTIVE + V_FP);
  localparam logic [CNTR_WIDTH_V-1:0] V_S1   = CNTR_WIDTH_V'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNTR_WIDTH_H-1:0] cx_q, cx_d;
  logic [CNTR_WIDTH_V-1:0] cy_q, cy_d;
  logic                    h_wrap;
  logic [2:0]              raw, al;
  logic [PW-1:0]           rgb_q, rgb_d;
  logic                    hs_q, hs_d, vs_q, vs_d, bn_q, bn_d;

  always_comb begin
    h_wrap = cx_q == H_LAST;
    cx_d   = h_wrap ? '0 : cx_q + 1'b1;
    cy_d   = !h_wrap ? cy_q : (cy_q == V_LAST ? '0 : cy_q + 1'b1);
    // {act, hs, vs}, all active-high internally so the reset/inactive value is zero
    raw    = {cx_q < H_ACT && cy_q < V_ACT,
              cx_q >= H_S0 && cx_q < H_S1,
              cy_q >= V_S0 && cy_q < V_S1};
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  if (PIX_LATENCY > 0) begin : g_dl
    logic [2:0] dl_q [PIX_LATENCY];
    logic [2:0] dl_d [PIX_LATENCY];
    always_comb begin
      dl_d[0] = raw;
      for (int i = 1; i < PIX_LATENCY; i++) dl_d[i] = dl_q[i-1];
    end
    always_ff @(posedge CLOCK) begin
      for (int i = 0; i < PIX_LATENCY; i++) dl_q[i] <= RESET ? 3'b000 : dl_d[i];
    end
    assign al = dl_q[PIX_LATENCY-1];
  end else begin : g_nodl
    assign al = raw;
  end

  always_comb begin
    rgb_d = al[2] ? PixBus : '0;
    bn_d  = al[2];
    hs_d  = ~al[1];
    vs_d  = ~al[0];
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rgb_q <= '0;
      bn_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      bn_q  <= bn_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign CounterX    = cx_q;
  assign CounterY    = cy_q;
  assign FrameStart  = cx_q == '0 && cy_q == '0 && !RESET;
  assign VGA_R       = rgb_q[R_WIDTH-1:0];
  assign VGA_G       = rgb_q[R_WIDTH+G_WIDTH-1:R_WIDTH];
  assign VGA_B       = rgb_q[PW-1:R_WIDTH+G_WIDTH];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = bn_q;
  assign VGA_SYNC_N  = 1'b0;
endmodule

// File: tb/tb_vga_raster_driver.sv
// tb_vga_raster_driver: random PixBus/RESET against a cycle-history model, latency 2 and latency 0
module tb_vga_raster_driver;
  localparam int HA = 16, HF = 2, HSY = 3, HB = 4, HT = HA + HF + HSY + HB;
  localparam int VA = 6, VF = 1, VSY = 2, VB = 2, VT = VA + VF + VSY + VB;
  localparam int N = 3000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [23:0] pix = '0;
  logic [10:0] cx0, cx1;
  logic [9:0] cy0, cy1;
  logic fs0, fs1, hs0, hs1, vs0, vs1, bn0, bn1, sn0, sn1;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  bit rst_h [N];
  logic [23:0] pix_h [N];
  int ex_h [N];
  int ey_h [N];
  int pass_n = 0;
  int tot_n = 0;

  always #5 clk = ~clk;

  vga_raster_driver #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .PIX_LATENCY(2)) u_l2 (
    .CLOCK(clk), .RESET(rst), .PixBus(pix), .CounterX(cx0), .CounterY(cy0), .FrameStart(fs0),
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_N(bn0), .VGA_SYNC_N(sn0));

  vga_raster_driver #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .PIX_LATENCY(0)) u_l0 (
    .CLOCK(clk), .RESET(rst), .PixBus(pix), .CounterX(cx1), .CounterY(cy1), .FrameStart(fs1),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_N(bn1), .VGA_SYNC_N(sn1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  // Expected pins in cycle t: {rgb[23:0], hs_n, vs_n, blank_n}. Pins reflect the counters
  // L+1 cycles back and the PixBus of the previous cycle, unless a reset fell in between.
  function automatic logic [26:0] pins(input int t, input int lat);
    int x, y;
    bit act, hsa, vsa;
    if (t - 1 - lat < 0) return {24'h0, 3'b110};
    for (int k = t - 1 - lat; k <= t - 1; k++) if (rst_h[k]) return {24'h0, 3'b110};
    x = ex_h[t-1-lat];
    y = ey_h[t-1-lat];
    act = x < HA && y < VA;
    hsa = x >= HA + HF && x < HA + HF + HSY;
    vsa = y >= VA + VF && y < VA + VF + VSY;
    return {act ? pix_h[t-1] : 24'h0, !hsa, !vsa, act};
  endfunction

  initial begin
    int n = 0;
    int last_fs = -1;
    int run = 0;
    bit dirty = 1'b1;
    logic prev_hs = 1'b1;
    logic [26:0] e;
    for (int t = 0; t < N; t++) begin
      @(posedge clk);
      #1;
      if (t == 0 || rst_h[t-1]) n = 0;
      else n++;
      ex_h[t] = n % HT;
      ey_h[t] = (n / HT) % VT;
      chk("cx_l2", cx0, ex_h[t]);
      chk("cy_l2", cy0, ey_h[t]);
      chk("cx_l0", cx1, ex_h[t]);
      chk("cy_l0", cy1, ey_h[t]);
      chk("sync_n", sn0, 0);
      e = pins(t, 2);
      chk("rgb_l2", {b0, g0, r0}, e[26:3]);
      chk("hs_l2", hs0, e[2]);
      chk("vs_l2", vs0, e[1]);
      chk("bn_l2", bn0, e[0]);
      e = pins(t, 0);
      chk("rgb_l0", {b1, g1, r1}, e[26:3]);
      chk("hs_l0", hs1, e[2]);
      chk("vs_l0", vs1, e[1]);
      chk("bn_l0", bn1, e[0]);
      if (hs0 == 1'b0) begin
        if (prev_hs) begin
          run = 0;
          dirty = 1'b0;
        end
        run++;
      end else if (!prev_hs && !dirty) chk("hs_width", run, HSY);
      prev_hs = hs0;
      rst = t < 4 || (t > 1200 && t < 2000 && $urandom_range(0, 149) == 0) || t == 2500;
      pix = $urandom;
      rst_h[t] = rst;
      pix_h[t] = pix;
      if (rst) begin
        dirty = 1'b1;
        last_fs = -1;
      end
      #1;
      chk("fs_l2", fs0, ex_h[t] == 0 && ey_h[t] == 0 && !rst);
      chk("fs_l0", fs1, ex_h[t] == 0 && ey_h[t] == 0 && !rst);
      if (fs0) begin
        if (last_fs >= 0) chk("fs_period", t - last_fs, HT * VT);
        last_fs = t;
      end
    end
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
